// File: rtl/count_register_0_99.sv
// Two-digit up/down event counter (0..99) kept as binary and as a BCD pair,
// fed by synchronized rising-edge events with full/empty and sticky range flags.

module count_register_0_99_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic evt_o
);
    logic sync1_q, sync2_q, prev_q, evt_q;

    // Two synchronizer flops, one edge-detect flop, then a registered pulse so
    // an input first sampled at edge k is applied to the count at edge k+3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            evt_q   <= sync2_q & ~prev_q;
        end
    end

    assign evt_o = evt_q;
endmodule

module count_register_0_99 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_in,
    input  logic       dec_in,
    input  logic       clear,
    input  logic       enable,
    output logic [6:0] reg_data,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       full,
    output logic       empty,
    output logic       cont_superior_99,
    output logic       underflow
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LIMIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] count_q, count_d;
    logic [3:0] units_q, units_d;
    logic [3:0] tens_q,  tens_d;
    logic       full_q,  full_d;
    logic       empty_q, empty_d;
    logic       sup_q,   sup_d;
    logic       unf_q,   unf_d;

    logic inc_evt, dec_evt;
    logic inc_ev,  dec_ev;

    count_register_0_99_edge u_inc_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_i (inc_in),
        .evt_o (inc_evt)
    );

    count_register_0_99_edge u_dec_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_i (dec_in),
        .evt_o (dec_evt)
    );

    // Coincident inc and dec events cancel each other.
    assign inc_ev = inc_evt & ~dec_evt;
    assign dec_ev = dec_evt & ~inc_evt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 7'd0;
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            sup_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            sup_q   <= sup_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        units_d = units_q;
        tens_d  = tens_q;
        sup_d   = sup_q;
        unf_d   = unf_q;

        if (clear) begin
            count_d = 7'd0;
            units_d = 4'd0;
            tens_d  = 4'd0;
            sup_d   = 1'b0;
            unf_d   = 1'b0;
            state_d = enable ? COUNT : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                COUNT: begin
                    if (enable && inc_ev) begin
                        if (count_q == 7'd99) begin
                            sup_d = 1'b1;
                        end else begin
                            count_d = count_q + 7'd1;
                            if (units_q == 4'd9) begin
                                units_d = 4'd0;
                                tens_d  = tens_q + 4'd1;
                            end else begin
                                units_d = units_q + 4'd1;
                            end
                        end
                    end else if (enable && dec_ev) begin
                        if (count_q == 7'd0) begin
                            unf_d = 1'b1;
                        end else begin
                            count_d = count_q - 7'd1;
                            if (units_q == 4'd0) begin
                                units_d = 4'd9;
                                tens_d  = tens_q - 4'd1;
                            end else begin
                                units_d = units_q - 4'd1;
                            end
                        end
                    end
                end
                LIMIT: begin
                    if (enable && inc_ev) begin
                        sup_d = 1'b1;
                    end else if (enable && dec_ev) begin
                        count_d = 7'd98;
                        units_d = 4'd8;
                        tens_d  = 4'd9;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (!enable)
                state_d = IDLE;
            else
                state_d = (count_d == 7'd99) ? LIMIT : COUNT;
        end

        full_d  = (count_d == 7'd99);
        empty_d = (count_d == 7'd0);
    end

    assign reg_data         = count_q;
    assign units            = units_q;
    assign tens             = tens_q;
    assign full             = full_q;
    assign empty            = empty_q;
    assign cont_superior_99 = sup_q;
    assign underflow        = unf_q;
endmodule

// File: doc/count_register_0_99.md
COUNT_REGISTER_0_99 -- requirements
Module: count_register_0_99

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 inc_in  input  1  asynchronous increment request (level; each rising edge is one event).
REQ-005 dec_in  input  1  asynchronous decrement request (level; each rising edge is one event).
REQ-006 clear  input  1  synchronous clear of count and flags, active-high.
REQ-007 enable  input  1  count enable, active-high.
REQ-008 reg_data  output  7  registered binary count, range 0..99.
REQ-009 units  output  4  registered BCD units digit of reg_data.
REQ-010 tens  output  4  registered BCD tens digit of reg_data.
REQ-011 full  output  1  registered; high when reg_data == 99.
REQ-012 empty  output  1  registered; high when reg_data == 0.
REQ-013 cont_superior_99  output  1  registered sticky flag; increment attempted while full.
REQ-014 underflow  output  1  registered sticky flag; decrement attempted while empty.

Function
REQ-015 inc_in and dec_in SHALL each pass through a 2-flop synchronizer followed by a third flop for rising-edge detection; one event per 0->1 transition.
REQ-016 Latency: an input first sampled high at edge k SHALL update reg_data/units/tens/full/empty at edge k+3.
REQ-017 A level held high SHALL produce exactly one event; a new event requires a return to 0 for at least 1 sampled cycle.
REQ-018 FSM states: IDLE (enable=0), COUNT (enable=1, 0 <= count < 99), LIMIT (enable=1, count == 99).
REQ-019 IDLE: events SHALL be discarded, count held, flags held; enable 0->1 SHALL move to COUNT or LIMIT per current count on the next edge.
REQ-020 COUNT: inc event -> count+1, moving to LIMIT when the result is 99; dec event -> count-1 when count > 0.
REQ-021 LIMIT: inc event SHALL leave count at 99 and set cont_superior_99; dec event -> 98 and move to COUNT.
REQ-022 dec event with count == 0 SHALL leave count at 0 and set underflow.
REQ-023 Simultaneous inc and dec events in the same cycle SHALL cancel: count unchanged, no flag set.
REQ-024 units/tens SHALL be maintained as a BCD counter pair in lockstep with reg_data, without a divider: units 9->0 carries into tens; units 0->9 borrows from tens.
REQ-025 Invariant: reg_data == 10*tens + units at every edge; reg_data never exceeds 99 (a value >= 100 SHALL never appear).
REQ-026 clear SHALL have priority over events and enable: on that edge count = 0, units = tens = 0, empty = 1, full = 0, both sticky flags = 0, state = IDLE or COUNT per enable.
REQ-027 Synchronizer and edge flops SHALL keep running during clear and IDLE; an edge arriving during clear SHALL be discarded.
REQ-028 Sticky flags SHALL clear only on clear or reset.

Reset
REQ-029 While rst_n is sampled 0 at a rising edge: reg_data = 0, units = 0, tens = 0, empty = 1, full = 0, cont_superior_99 = 0, underflow = 0, state = IDLE, and all synchronizer and edge flops = 0.
REQ-030 Reset SHALL take priority over clear, enable and events, and SHALL abort any in-flight synchronized event.
REQ-031 The first event accepted after rst_n rises SHALL require a fresh 0->1 transition seen by the synchronizer.

Verification
REQ-032 Reset, enable=1, 12 single inc pulses -> reg_data=12, tens=1, units=2, empty=0, full=0.
REQ-033 Count from 0 to 99 by incs, then 3 more incs -> reg_data stays 99, full=1, cont_superior_99=1; next dec -> 98, full=0, flag still 1.
REQ-034 Count 0, one dec -> reg_data=0, underflow=1, empty=1; then clear -> both flags 0.
REQ-035 Count 40, inc and dec rising in the same cycle -> reg_data=40, no flag change; inc held high 20 cycles -> exactly 41.
REQ-036 Count 19 + inc -> tens=2, units=0; count 20 + dec -> tens=1, units=9; inc sampled at edge k -> update visible at edge k+3.
REQ-037 Count 57, enable=0 with 5 incs -> stays 57; inc edge concurrent with clear -> 0; rst_n=0 mid-synchronization -> all outputs at reset values and no event applied after release.
